// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: reads a big-endian 16-bit instruction as two bytes
// from a byte-wide memory, then holds it for decode under a valid/ready handshake.
module fetch_sequencer #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_BYTES = 16,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PC_MASK  = ADDR_W'(MEM_BYTES - 1);
  localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    F_HI = 2'd0,
    F_LO = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [7:0]          hi_q, hi_d;
  logic [15:0]         instr_q, instr_d;
  logic [ADDR_W-1:0]   ipc_q, ipc_d;
  logic                valid_q, valid_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= F_HI;
      pc_q    <= PC_RESET & PC_MASK;
      hi_q    <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hi_q    <= hi_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hi_d    = hi_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;

    // Redirect overrides everything, including a coincident handshake in HOLD:
    // the held instruction is dropped (or counted as consumed) and the target wins over pc+2.
    if (redirect_valid) begin
      pc_d    = {redirect_pc[ADDR_W-1:1], 1'b0} & PC_MASK;
      valid_d = 1'b0;
      state_d = F_HI;
    end else begin
      unique case (state_q)
        F_HI: begin
          if (!halt) begin
            hi_d    = mem_rdata;
            state_d = F_LO;
          end
        end
        F_LO: begin
          instr_d = {hi_q, mem_rdata};
          ipc_d   = pc_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end
        HOLD: begin
          if (instr_ready) begin
            valid_d = 1'b0;
            pc_d    = (pc_q + ADDR_W'(2)) & PC_MASK;
            state_d = F_HI;
          end
        end
        default: state_d = F_HI;
      endcase
    end
  end

  always_comb begin
    mem_addr = pc_q;
    if (state_q == F_LO) mem_addr = (pc_q + ADDR_W'(1)) & PC_MASK;
  end

  assign busy        = (state_q != HOLD);
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a byte memory model feeds the DUT and a
// queue of expected {instr, pc} entries is checked at every handshake.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halt;
  logic        busy;

  logic [7:0]  mem [16];
  logic [23:0] sb [$];
  int          vectors;
  int          errs;

  fetch_sequencer #(.ADDR_W(8), .MEM_BYTES(16), .RESET_PC(0)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .busy           (busy)
  );

  assign mem_rdata = mem[mem_addr[3:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int unsigned pc);
    logic [3:0] a;
    logic [3:0] b;
    a = 4'(pc);
    b = 4'(pc + 1);
    sb.push_back({mem[a], mem[b], 8'(pc)});
  endtask

  // Called at a falling edge with inputs settled: a valid&ready now is a handshake
  // at the coming rising edge, so the delivered word is scored before advancing.
  task automatic step();
    logic [23:0] e;
    if (instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_handshake", {16'h0, instr_pc}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("sb_instr", 32'(instr), 32'(e[23:8]));
        check("sb_pc", 32'(instr_pc), 32'(e[7:0]));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] init_mem [16];
    logic       vpat [6];
    logic [7:0] apat [6];
    logic       bpat [6];
    init_mem = '{8'h11, 8'h21, 8'h25, 8'h52, 8'h30, 8'h31, 8'h40, 8'h41,
                 8'h50, 8'h51, 8'h60, 8'h61, 8'h70, 8'h71, 8'hF1, 8'h42};
    foreach (init_mem[i]) mem[i] = init_mem[i];
    vpat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    apat = '{8'd1, 8'd0, 8'd2, 8'd3, 8'd2, 8'd4};
    bpat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vectors = 0;
    errs = 0;

    reset = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_pc", 32'(instr_pc), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

    // T1: streaming with ready high, one instruction per three cycles
    instr_ready = 1'b1;
    push_exp(0);
    push_exp(2);
    reset = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      step();
      check($sformatf("t1_valid_%0d", k), 32'(instr_valid), 32'(vpat[k]));
      check($sformatf("t1_addr_%0d", k), 32'(mem_addr), 32'(apat[k]));
      check($sformatf("t1_busy_%0d", k), 32'(busy), 32'(bpat[k]));
    end
    instr_ready = 1'b0;

    // T2: back-pressure holds the word and the pc
    push_exp(4);
    step();
    step();
    check("t2_valid", 32'(instr_valid), 32'd1);
    check("t2_instr", 32'(instr), 32'h3031);
    for (int unsigned k = 0; k < 5; k++) begin
      step();
      check($sformatf("t2_hold_instr_%0d", k), 32'(instr), 32'h3031);
      check($sformatf("t2_hold_pc_%0d", k), 32'(instr_pc), 32'd4);
      check($sformatf("t2_hold_addr_%0d", k), 32'(mem_addr), 32'd4);
      check($sformatf("t2_hold_valid_%0d", k), 32'(instr_valid), 32'd1);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t2_after_valid", 32'(instr_valid), 32'd0);
    check("t2_after_addr", 32'(mem_addr), 32'd6);
    step();
    step();
    check("t2_next_pc", 32'(instr_pc), 32'd6);
    check("t2_next_instr", 32'(instr), 32'h4041);

    // T3: redirect drops the held word, then fetch at 14 wraps to 0
    redirect_valid = 1'b1;
    redirect_pc = 8'd14;
    step();
    redirect_valid = 1'b0;
    check("t3_drop_valid", 32'(instr_valid), 32'd0);
    check("t3_addr_hi", 32'(mem_addr), 32'd14);
    instr_ready = 1'b1;
    push_exp(14);
    step();
    check("t3_addr_lo", 32'(mem_addr), 32'd15);
    step();
    step();
    check("t3_wrap_addr", 32'(mem_addr), 32'd0);
    instr_ready = 1'b0;

    // T4: redirect to an odd target during F_LO
    step();
    check("t4_in_flo", 32'(mem_addr), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 8'h07;
    step();
    redirect_valid = 1'b0;
    check("t4_addr", 32'(mem_addr), 32'd6);
    check("t4_valid", 32'(instr_valid), 32'd0);
    push_exp(6);
    instr_ready = 1'b1;
    step();
    step();
    step();
    instr_ready = 1'b0;

    // T5: redirect coincident with handshake
    push_exp(8);
    step();
    step();
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 8'h0C;
    step();
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    check("t5_valid", 32'(instr_valid), 32'd0);
    check("t5_addr", 32'(mem_addr), 32'd12);
    push_exp(12);
    instr_ready = 1'b1;
    step();
    step();
    check("t5_pc", 32'(instr_pc), 32'd12);
    step();
    instr_ready = 1'b0;

    // T6: halt raised in F_LO, then async reset while holding
    push_exp(14);
    step();
    halt = 1'b1;
    step();
    check("t6_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      check($sformatf("t6_halt_valid_%0d", k), 32'(instr_valid), 32'd0);
      check($sformatf("t6_halt_busy_%0d", k), 32'(busy), 32'd1);
      check($sformatf("t6_halt_addr_%0d", k), 32'(mem_addr), 32'd0);
    end
    halt = 1'b0;
    instr_ready = 1'b1;
    push_exp(0);
    step();
    step();
    step();
    instr_ready = 1'b0;
    step();
    step();
    check("t6_hold_pc", 32'(instr_pc), 32'd2);
    check("t6_hold_valid", 32'(instr_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(instr_valid), 32'd0);
    check("t6_rst_addr", 32'(mem_addr), 32'd0);
    check("t6_rst_instr", 32'(instr), 32'd0);
    check("t6_rst_pc", 32'(instr_pc), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
